// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame size, transmitter state encoding, odd-parity helper.
// Combinational only; no handshake.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } ps2_state_e;

    // Parity bit that makes data plus parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte handshake into the PS/2 device transmitter.
// Transfer happens on a rising clk edge where tx_valid && tx_ready.
interface ps2_device_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/ps2_half_timer.sv
// Loadable down-counter; o_expire is high in the last cycle of a loaded interval (load value + 1 cycles).
// A load always wins over expiry, so back-to-back intervals need no idle cycle.
module ps2_half_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic         r_armed;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= i_load_val;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_cnt == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: one byte per handshake, 11-bit frame, 22*CLK_HALF cycles plus GAP_CYCLES idle.
// tx_ready is high only in IDLE; tx_valid while busy is ignored. All outputs registered.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF   = 2000,
    parameter int GAP_CYCLES = 4000
) (
    input  logic                  clk,
    input  logic                  resetn,
    ps2_device_tx_if.slave        tx_if,
    output logic                  ps2_clk,
    output logic                  ps2_data,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                r_state;
    logic [PS2_FRAME_BITS-2:0] r_shift;
    logic [3:0]                r_idx;
    logic                      r_ps2_clk;
    logic                      r_ps2_data;
    logic                      r_tx_ready;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_hs;
    logic                      w_expire;
    logic                      w_load;
    logic [CW-1:0]             w_load_val;

    assign w_hs = r_tx_ready && tx_if.tx_valid;

    // Timer is reloaded on every state entry; only LOW->GAP uses the gap length.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = HALF_LOAD;
        case (r_state)
            ST_IDLE: w_load = w_hs;
            ST_HIGH: w_load = w_expire;
            ST_LOW: begin
                w_load = w_expire;
                if (r_idx == LAST_IDX) begin
                    w_load_val = GAP_LOAD;
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    ps2_half_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_hs) begin
                        // Start bit goes straight to the line; shift holds d0..d7, parity, stop.
                        r_shift    <= {1'b1, odd_parity(tx_if.tx_data), tx_if.tx_data};
                        r_idx      <= '0;
                        r_state    <= ST_HIGH;
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_expire) begin
                        r_state   <= ST_LOW;
                        r_ps2_clk <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (w_expire) begin
                        r_ps2_clk <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state    <= ST_GAP;
                            r_ps2_data <= 1'b1;
                        end else begin
                            r_state    <= ST_HIGH;
                            r_idx      <= r_idx + 1'b1;
                            r_ps2_data <= r_shift[0];
                            r_shift    <= {1'b1, r_shift[PS2_FRAME_BITS-2:1]};
                        end
                    end
                end
                ST_GAP: begin
                    if (w_expire) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_if.tx_ready = r_tx_ready;
    assign ps2_clk        = r_ps2_clk;
    assign ps2_data       = r_ps2_data;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
